mem_arbiter: RTL and testbench

- Two-port access controller in front of the single-port `memory` block (combinational read and write while `en`=1, write when `ctrl`=1).
- Arbitrates between an instruction-fetch requester (port F) and a data load/store requester (port D).
- Sequences each access as a fixed multi-cycle `en` window and returns read data with a one-cycle ack pulse, modelling the LC-3 memory-ready (R) handshake.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter sequencing fixed-latency accesses to a single-port memory
// Each access holds mem_en for LATENCY cycles, then pulses the granted port's ack one cycle later.
module mem_arbiter #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 16,
  parameter int LATENCY   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 f_req_i,
  input  logic [ADDR_SIZE-1:0] f_addr_i,
  output logic                 f_ack_o,
  output logic [DATA_SIZE-1:0] f_rdata_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [ADDR_SIZE-1:0] d_addr_i,
  input  logic [DATA_SIZE-1:0] d_wdata_i,
  output logic                 d_ack_o,
  output logic [DATA_SIZE-1:0] d_rdata_o,
  output logic                 mem_en_o,
  output logic                 mem_ctrl_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [DATA_SIZE-1:0] mem_in_o,
  input  logic [DATA_SIZE-1:0] mem_out_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_f_q, last_f_d;   // 0 = last grant went to D
  logic                  sel_d_q, sel_d_d;     // 1 = current access belongs to D
  logic                  en_q, en_d;
  logic                  ctrl_q, ctrl_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
  logic                  f_ack_q, f_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_SIZE-1:0]  f_rdata_q, f_rdata_d;
  logic [DATA_SIZE-1:0]  d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant_to_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_f_d   = last_f_q;
    sel_d_d    = sel_d_q;
    en_d       = en_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    busy_d     = busy_q;
    grant_to_d = d_req_i && (!f_req_i || last_f_q);

    case (state_q)
      IDLE: begin
        if (f_req_i || d_req_i) begin
          sel_d_d  = grant_to_d;
          last_f_d = !grant_to_d;
          addr_d   = grant_to_d ? d_addr_i : f_addr_i;
          wdata_d  = d_wdata_i;
          ctrl_d   = grant_to_d && d_we_i;
          en_d     = 1'b1;
          cnt_d    = CNT_INIT;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // mem_out is combinational, so it is valid while mem_en is still high
          if (!ctrl_q) begin
            if (sel_d_q) d_rdata_d = mem_out_i;
            else         f_rdata_d = mem_out_i;
          end
          en_d    = 1'b0;
          ctrl_d  = 1'b0;
          f_ack_d = !sel_d_q;
          d_ack_d = sel_d_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_f_q  <= 1'b0;
      sel_d_q   <= 1'b0;
      en_q      <= 1'b0;
      ctrl_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_f_q  <= last_f_d;
      sel_d_q   <= sel_d_d;
      en_q      <= en_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign f_ack_o    = f_ack_q;
  assign d_ack_o    = d_ack_q;
  assign f_rdata_o  = f_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign mem_en_o   = en_q;
  assign mem_ctrl_o = ctrl_q;
  assign mem_addr_o = addr_q;
  assign mem_in_o   = wdata_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a transaction-level timing model
module tb_mem_arbiter;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_mem = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic        f_ack, d_ack, mem_en, mem_ctrl, busy;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_in, mem_out;

  logic        f1_req = 1'b0;
  logic [15:0] f1_addr = '0;
  logic        f1_ack, d1_ack, mem_en1, mem_ctrl1, busy1;
  logic [15:0] f1_rdata, d1_rdata, mem_addr1, mem_in1, mem_out1;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack), .f_rdata_o(f_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_ctrl_o(mem_ctrl), .mem_addr_o(mem_addr), .mem_in_o(mem_in),
    .mem_out_i(mem_out), .busy_o(busy)
  );

  mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f1_req), .f_addr_i(f1_addr), .f_ack_o(f1_ack), .f_rdata_o(f1_rdata),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(16'h0000), .d_wdata_i(16'h0000),
    .d_ack_o(d1_ack), .d_rdata_o(d1_rdata),
    .mem_en_o(mem_en1), .mem_ctrl_o(mem_ctrl1), .mem_addr_o(mem_addr1), .mem_in_o(mem_in1),
    .mem_out_i(mem_out1), .busy_o(busy1)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 3) ? 16'h1234 : 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  logic [15:0] fix_mem [0:15];
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 16; i++) fix_mem[i] <= init_val(i);
    else if (mem_en && mem_ctrl) fix_mem[mem_addr[3:0]] <= mem_in;
  end
  assign mem_out  = fix_mem[mem_addr[3:0]];
  assign mem_out1 = mem_addr1 ^ 16'hA5A5;

  // transaction-level reference: one access in flight, timed from its grant edge
  logic [15:0] ref_mem [0:15];
  int          e = 0, g = 0, cyc = 0;
  logic        act_valid = 1'b0, act_d = 1'b0, act_store = 1'b0, last_d = 1'b1;
  logic [15:0] act_addr = '0, act_wdata = '0, act_rdata = '0;
  logic        exp_en = 1'b0, exp_ack = 1'b0, exp_busy = 1'b0;
  logic [15:0] exp_frd = '0, exp_drd = '0;

  int f_want = 0, f_done = 0, d_want = 0, d_done = 0;
  logic        rnd = 1'b0, scramble = 1'b0, d_next_we = 1'b0;
  logic [15:0] f_next_addr = '0, d_next_addr = '0, d_next_wdata = '0, scr_addr = '0;
  int ack_log[$];
  int ack_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int c;
    logic pick_d;
    if (init_mem) for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    if (!rst_n) begin
      act_valid = 1'b0; last_d = 1'b1; exp_frd = '0; exp_drd = '0;
    end else begin
      if (act_valid && e >= g + L + 2) act_valid = 1'b0;
      if (!act_valid && (f_req || d_req)) begin
        pick_d    = (f_req && d_req) ? !last_d : d_req;
        last_d    = pick_d;
        act_valid = 1'b1;
        act_d     = pick_d;
        g         = e;
        act_addr  = pick_d ? d_addr : f_addr;
        act_store = pick_d && d_we;
        act_wdata = d_wdata;
        if (act_store) ref_mem[act_addr[3:0]] = d_wdata;
        else act_rdata = ref_mem[act_addr[3:0]];
      end
    end
    c = e + 1;
    exp_en   = act_valid && c >= g + 1 && c <= g + L;
    exp_ack  = act_valid && c == g + L + 1;
    exp_busy = act_valid && c <= g + L + 1;
    if (exp_ack && !act_store) begin
      if (act_d) exp_drd = act_rdata;
      else       exp_frd = act_rdata;
    end
    e++;
  endtask

  task automatic check_outputs();
    check_val("f_ack", f_ack, exp_ack && !act_d);
    check_val("d_ack", d_ack, exp_ack && act_d);
    check_val("mem_en", mem_en, exp_en);
    check_val("mem_ctrl", mem_ctrl, exp_en && act_store);
    check_val("busy", busy, exp_busy);
    check_val("f_rdata", f_rdata, exp_frd);
    check_val("d_rdata", d_rdata, exp_drd);
    if (exp_en) check_val("mem_addr", mem_addr, act_addr);
    if (exp_en && act_store) check_val("mem_in", mem_in, act_wdata);
  endtask

  task automatic drive();
    if (!rst_n) begin
      f_req = 1'b0; d_req = 1'b0; f_done = f_want; d_done = d_want;
      return;
    end
    if (f_req && f_ack) begin
      f_done++; ack_log.push_back(0); ack_cyc.push_back(cyc); f_req = 1'b0;
    end
    if (!f_req && f_done < f_want) begin
      f_req  = 1'b1;
      f_addr = rnd ? 16'($urandom_range(0, 15)) : f_next_addr;
    end else if (f_req && scramble && exp_en && !act_d) begin
      f_addr = rnd ? 16'($urandom_range(0, 15)) : scr_addr;
    end
    if (d_req && d_ack) begin
      d_done++; ack_log.push_back(1); ack_cyc.push_back(cyc); d_req = 1'b0;
    end
    if (!d_req && d_done < d_want) begin
      d_req   = 1'b1;
      d_addr  = rnd ? 16'($urandom_range(0, 15)) : d_next_addr;
      d_we    = rnd ? 1'($urandom_range(0, 1)) : d_next_we;
      d_wdata = rnd ? 16'($urandom) : d_next_wdata;
    end else if (d_req && scramble && exp_en && act_d) begin
      d_addr  = rnd ? 16'($urandom_range(0, 15)) : scr_addr;
      d_wdata = 16'($urandom);
      d_we    = rnd ? 1'($urandom_range(0, 1)) : !d_we;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
    drive();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((f_done != f_want || d_done != d_want) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      check_val("timeout_f", f_done, f_want);
      check_val("timeout_d", d_done, d_want);
    end
    tick();
    tick();
  endtask

  initial begin
    int s, en_cnt, ack_at, busy_cnt, d1_seen;
    repeat (3) tick();
    check_val("rst_mem_addr", mem_addr, 16'h0000);
    init_mem = 1'b0;
    rst_n    = 1'b1;
    tick();

    // fetch aborted by reset while BUSY
    f_next_addr = 16'h0004;
    f_want++;
    repeat (3) tick();
    check_val("pre_rst_en", mem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rst_en", mem_en, 1'b0);
    check_val("async_rst_busy", busy, 1'b0);
    check_val("async_rst_fack", f_ack, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_val("abort_no_ack", ack_log.size(), 0);

    // both requests after reset: F wins because last_grant resets to D
    f_next_addr = 16'h0002;
    d_next_addr = 16'h0001; d_next_we = 1'b0;
    f_want++; d_want++;
    wait_idle();
    check_val("first_grant_f", ack_log[0], 0);
    check_val("second_grant_d", ack_log[1], 1);

    f_next_addr = 16'h0003;
    f_want++;
    wait_idle();
    check_val("fetch_rdata", f_rdata, 16'h1234);
    check_val("fetch_keeps_drd", d_rdata, init_val(1));

    // store with address changed mid-access, then loads
    scramble = 1'b1; scr_addr = 16'h0007;
    d_next_addr = 16'h0005; d_next_we = 1'b1; d_next_wdata = 16'hBEEF;
    d_want++;
    wait_idle();
    check_val("store_keeps_drd", d_rdata, init_val(1));
    d_next_we = 1'b0;
    d_want++;
    wait_idle();
    check_val("load_beef", d_rdata, 16'hBEEF);
    scramble = 1'b0;
    d_next_addr = 16'h0007;
    d_want++;
    wait_idle();
    check_val("addr7_untouched", d_rdata, init_val(7));

    // continuous contention
    s = ack_log.size();
    f_next_addr = 16'h0003; d_next_addr = 16'h0005;
    f_want += 2; d_want += 2;
    wait_idle();
    check_val("cont_count", ack_log.size() - s, 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("cont_order%0d", i), ack_log[s+i], i % 2);
    for (int i = 1; i < 4; i++) check_val($sformatf("cont_gap%0d", i), ack_cyc[s+i] - ack_cyc[s+i-1], L + 2);

    // randomized traffic
    rnd = 1'b1; scramble = 1'b1;
    for (int r = 0; r < 60; r++) begin
      f_want += $urandom_range(0, 2);
      d_want += $urandom_range(0, 2);
      repeat ($urandom_range(1, 10)) tick();
    end
    wait_idle();
    rnd = 1'b0; scramble = 1'b0;

    // LATENCY=1 instance
    en_cnt = 0; ack_at = 0; busy_cnt = 0; d1_seen = 0;
    f1_addr = 16'h0009;
    f1_req  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_en1) en_cnt++;
      if (busy1) busy_cnt++;
      if (d1_ack) d1_seen++;
      if (f1_ack) begin
        ack_at = i;
        f1_req = 1'b0;
      end
    end
    check_val("l1_en_cycles", en_cnt, 1);
    check_val("l1_ack_at", ack_at, 2);
    check_val("l1_busy_cycles", busy_cnt, 2);
    check_val("l1_rdata", f1_rdata, 16'h0009 ^ 16'hA5A5);
    check_val("l1_no_dack", d1_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
